// File: rtl/irq_ctrl_6502.sv
// ---------------------------------------------------------------------------
// irq_ctrl_6502
//
// Memory-mapped interrupt controller for a 6502 system bus. External sources
// are synchronised, latched as pending (edge or level per source), masked,
// prioritised and folded into a single registered IRQ line for the CPU.
//
// Register window (BaseAddress + offset):
//   +0 STATUS  pending bits, write-1-to-clear
//   +1 ENABLE  per-source mask
//   +2 MODE    per-source trigger: 1 = rising edge, 0 = level
//   +3 VECTOR  lowest pending&enabled index in [2:0], 'h80 when none (RO)
//   +4 CTRL    [0] global enable, [1] clear-all strobe (reads 0)
//   +5 SWSET   write 1s to set pending bits (reads 0)
//
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   address_i  CPU address, qualified together with rd_wr_i / data_i
//   data_i     CPU write data
//   rd_wr_i    1 = write, 0 = read
//   data_o     registered read data, holds between in-window reads
//   irq_src_i  asynchronous active-high interrupt sources
//   irq_o      registered interrupt request to the CPU
// ---------------------------------------------------------------------------
module irq_ctrl_6502 #(
    parameter int unsigned BaseAddress   = 'h9400,
    parameter int unsigned NumSources    = 8,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned address_width = 16,
    parameter int unsigned data_width    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [data_width-1:0]    data_o,
    input  logic [NumSources-1:0]    irq_src_i,
    output logic                     irq_o
);

    localparam logic [address_width-1:0] BASE_ADDR = address_width'(BaseAddress);

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_ENABLE = 3'd1;
    localparam logic [2:0] OFF_MODE   = 3'd2;
    localparam logic [2:0] OFF_VECTOR = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_SWSET  = 3'd5;

    logic [NumSources-1:0] pending_reg;
    logic [NumSources-1:0] enable_reg;
    logic [NumSources-1:0] mode_reg;
    logic                  ctrl_en_reg;
    logic [NumSources-1:0] prev_reg;

    logic [NumSources-1:0] pending_next;
    logic [NumSources-1:0] sync_s;
    logic [NumSources-1:0] set_vec;
    logic [NumSources-1:0] clear_vec;
    logic [NumSources-1:0] swset_vec;
    logic [NumSources-1:0] masked;
    logic [NumSources-1:0] src_data;

    logic [address_width-1:0] offset;
    logic [2:0]               off_sel;
    logic                     in_window;
    logic                     wr_sel;
    logic                     rd_sel;
    logic                     clear_all;

    logic                     vec_valid;
    logic [2:0]               vec_idx;
    logic [data_width-1:0]    rd_data;

    // Subtracting the base folds addresses below the window into large
    // offsets, so one unsigned compare bounds both ends of the window.
    assign offset    = address_i - BASE_ADDR;
    assign in_window = (offset < address_width'(6));
    assign off_sel   = offset[2:0];
    assign wr_sel    = in_window & rd_wr_i;
    assign rd_sel    = in_window & ~rd_wr_i;
    assign src_data  = data_i[NumSources-1:0];

    assign clear_all = wr_sel && (off_sel == OFF_CTRL) && data_i[1];
    assign clear_vec = ((wr_sel && (off_sel == OFF_STATUS)) ? src_data : '0)
                     | {NumSources{clear_all}};
    assign swset_vec = (wr_sel && (off_sel == OFF_SWSET)) ? src_data : '0;
    assign masked    = pending_reg & enable_reg;

    generate
        for (genvar gi = 0; gi < NumSources; gi++) begin : g_src
            logic [SyncStages-1:0] sync_reg;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SyncStages-2:0], irq_src_i[gi]};
                end
            end

            assign sync_s[gi] = sync_reg[SyncStages-1];

            // Set is OR-ed in after the clear so a coincident event is never lost.
            assign set_vec[gi] = (mode_reg[gi] ? (sync_s[gi] & ~prev_reg[gi]) : sync_s[gi])
                               | swset_vec[gi];
            assign pending_next[gi] = (pending_reg[gi] & ~clear_vec[gi]) | set_vec[gi];
        end
    endgenerate

    // Lowest-numbered pending and enabled source wins: scan downwards so the
    // last hit is the lowest index.
    always_comb begin
        vec_valid = 1'b0;
        vec_idx   = '0;
        for (int i = int'(NumSources) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                vec_valid = 1'b1;
                vec_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (off_sel)
            OFF_STATUS: rd_data = data_width'(pending_reg);
            OFF_ENABLE: rd_data = data_width'(enable_reg);
            OFF_MODE:   rd_data = data_width'(mode_reg);
            OFF_VECTOR: rd_data = vec_valid ? data_width'(vec_idx) : data_width'(8'h80);
            OFF_CTRL:   rd_data = data_width'(ctrl_en_reg);
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_reg <= '0;
            enable_reg  <= '0;
            mode_reg    <= '0;
            ctrl_en_reg <= 1'b0;
            prev_reg    <= '0;
            data_o      <= '0;
            irq_o       <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            prev_reg    <= sync_s;
            // Uses pre-edge pending so irq trails the pending flag by one edge.
            irq_o       <= ctrl_en_reg & (|masked);

            if (wr_sel && (off_sel == OFF_ENABLE)) begin
                enable_reg <= src_data;
            end
            if (wr_sel && (off_sel == OFF_MODE)) begin
                mode_reg <= src_data;
            end
            if (wr_sel && (off_sel == OFF_CTRL)) begin
                ctrl_en_reg <= data_i[0];
            end
            if (rd_sel) begin
                data_o <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl_6502.sv
module tb_irq_ctrl_6502;

    localparam logic [15:0] BASE = 16'h9400;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] address_i = IDLE;
    logic [7:0]  data_i = 8'h00;
    logic        rd_wr_i = 1'b0;
    logic [7:0]  data_o;
    logic [7:0]  irq_src_i = 8'h00;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    irq_ctrl_6502 dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .address_i (address_i),
        .data_i    (data_i),
        .rd_wr_i   (rd_wr_i),
        .data_o    (data_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: register file semantics evaluated once per edge.
    // Synchroniser is a plain delay line of sampled source words.
    // ------------------------------------------------------------------
    logic [7:0] m_pend = 0, m_en = 0, m_mode = 0, m_s = 0, m_prev = 0;
    logic       m_ctrl = 0, m_irq = 0;
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         rd_seen = 0;
    bit         started = 0;

    always @(posedge clk_i) begin : model
        logic [7:0] evt, setv, clrv, swv, rdv, masked_m;
        logic [15:0] off;
        bit in_win, wr, rd;
        if (reset_i) begin
            m_pend = 0; m_en = 0; m_mode = 0; m_ctrl = 0;
            m_prev = 0; m_s = 0; m_irq = 0;
            m_q = {8'h00, 8'h00};
            exp_q.push_back(8'h00);
            rd_seen = 1;
            started = 1;
        end else if (started) begin
            in_win = (address_i >= BASE) && (address_i <= BASE + 16'd5);
            off    = address_i - BASE;
            wr     = in_win && rd_wr_i;
            rd     = in_win && !rd_wr_i;
            masked_m = m_pend & m_en;
            rdv = 8'h00;
            case (off)
                16'd0: rdv = m_pend;
                16'd1: rdv = m_en;
                16'd2: rdv = m_mode;
                16'd3: begin
                    rdv = 8'h80;
                    for (int i = 0; i < 8; i++) begin
                        if (masked_m[i]) begin
                            rdv = 8'(i);
                            break;
                        end
                    end
                end
                16'd4: rdv = {7'd0, m_ctrl};
                default: rdv = 8'h00;
            endcase
            evt  = m_s & ~m_prev;
            swv  = (wr && off == 16'd5) ? data_i : 8'h00;
            clrv = ((wr && off == 16'd0) ? data_i : 8'h00)
                 | ((wr && off == 16'd4 && data_i[1]) ? 8'hFF : 8'h00);
            setv = (m_mode & evt) | (~m_mode & m_s) | swv;
            m_irq  = m_ctrl && (masked_m != 0);
            m_pend = (m_pend & ~clrv) | setv;
            if (wr && off == 16'd1) m_en = data_i;
            if (wr && off == 16'd2) m_mode = data_i;
            if (wr && off == 16'd4) m_ctrl = data_i[0];
            if (rd) begin
                exp_q.push_back(rdv);
                rd_seen = 1;
            end else begin
                rd_seen = 0;
            end
            m_prev = m_s;
            m_q.push_back(irq_src_i);
            void'(m_q.pop_front());
            m_s = m_q[0];
        end
    end

    // Monitor: pops the scoreboard whenever a read result is presented.
    always @(negedge clk_i) begin
        if (started) begin
            check("irq_o_model", {31'd0, irq_o}, {31'd0, m_irq});
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    check("data_o_model", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic wr(input logic [2:0] off, input logic [7:0] val);
        @(negedge clk_i);
        address_i = BASE + {13'd0, off};
        rd_wr_i   = 1'b1;
        data_i    = val;
        @(negedge clk_i);
        address_i = IDLE;
        rd_wr_i   = 1'b0;
        $display("WR off=%0d data=%02h", off, val);
    endtask

    task automatic rd_expect(input string name, input logic [2:0] off, input logic [7:0] exp);
        @(negedge clk_i);
        address_i = BASE + {13'd0, off};
        rd_wr_i   = 1'b0;
        @(negedge clk_i);
        address_i = IDLE;
        $display("RD off=%0d data=%02h", off, data_o);
        check(name, {24'd0, data_o}, {24'd0, exp});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset state
        wait_cycles(3);
        reset_i = 1'b0;
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_data", {24'd0, data_o}, 32'd0);
        rd_expect("reset_status", 3'd0, 8'h00);
        rd_expect("reset_enable", 3'd1, 8'h00);
        rd_expect("reset_mode",   3'd2, 8'h00);
        rd_expect("reset_vector", 3'd3, 8'h80);
        rd_expect("reset_ctrl",   3'd4, 8'h00);

        // Edge mode on source 3
        wr(3'd1, 8'h08);
        wr(3'd2, 8'h08);
        wr(3'd4, 8'h01);
        irq_src_i[3] = 1'b1;
        @(negedge clk_i);
        irq_src_i[3] = 1'b0;
        wait_cycles(2);
        check("edge_irq_n2", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        check("edge_irq_n3", {31'd0, irq_o}, 32'd1);
        rd_expect("edge_status", 3'd0, 8'h08);
        rd_expect("edge_vector", 3'd3, 8'h03);
        wr(3'd0, 8'h08);
        check("w1c_irq_m", {31'd0, irq_o}, 32'd1);
        @(negedge clk_i);
        check("w1c_irq_m1", {31'd0, irq_o}, 32'd0);
        rd_expect("w1c_vector", 3'd3, 8'h80);

        // Level mode on source 0
        irq_src_i[0] = 1'b1;
        wr(3'd1, 8'h01);
        wr(3'd4, 8'h01);
        wr(3'd0, 8'h01);
        rd_expect("level_status", 3'd0, 8'h01);
        check("level_irq", {31'd0, irq_o}, 32'd1);
        irq_src_i[0] = 1'b0;
        wait_cycles(4);
        wr(3'd0, 8'h01);
        wait_cycles(2);
        check("level_irq_clr", {31'd0, irq_o}, 32'd0);

        // Priority and masking
        wr(3'd4, 8'h00);
        wr(3'd5, 8'hA4);
        wr(3'd1, 8'hA0);
        rd_expect("prio_vector", 3'd3, 8'h05);
        rd_expect("prio_status", 3'd0, 8'hA4);
        rd_expect("swset_reads0", 3'd5, 8'h00);
        check("prio_irq_gdis", {31'd0, irq_o}, 32'd0);
        wr(3'd4, 8'h01);
        @(negedge clk_i);
        check("prio_irq_gen", {31'd0, irq_o}, 32'd1);

        // Simultaneous edge event and W1C on source 2
        wr(3'd4, 8'h03);
        wr(3'd2, 8'h0C);
        irq_src_i[2] = 1'b1;
        wait_cycles(2);
        address_i = BASE;
        rd_wr_i   = 1'b1;
        data_i    = 8'h04;
        @(negedge clk_i);
        address_i = IDLE;
        rd_wr_i   = 1'b0;
        $display("WR off=0 data=04 (coincident with edge event)");
        rd_expect("simul_status", 3'd0, 8'h04);
        wr(3'd4, 8'h03);
        rd_expect("clrall_status", 3'd0, 8'h00);
        rd_expect("clrall_ctrl", 3'd4, 8'h01);
        irq_src_i[2] = 1'b0;

        // Reset mid-operation
        wr(3'd1, 8'hFF);
        wr(3'd5, 8'hFF);
        @(negedge clk_i);
        check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
        irq_src_i[1] = 1'b1;
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check("midreset_irq", {31'd0, irq_o}, 32'd0);
        check("midreset_data", {24'd0, data_o}, 32'd0);
        rd_expect("midreset_enable", 3'd1, 8'h00);
        rd_expect("midreset_mode",   3'd2, 8'h00);
        rd_expect("midreset_vector", 3'd3, 8'h80);
        rd_expect("midreset_ctrl",   3'd4, 8'h00);
        rd_expect("midreset_status", 3'd0, 8'h02);
        check("midreset_irq_after", {31'd0, irq_o}, 32'd0);
        irq_src_i[1] = 1'b0;

        // Randomised traffic checked by the model through the scoreboard
        for (int n = 0; n < 400; n++) begin
            int sel;
            @(negedge clk_i);
            sel       = $urandom_range(0, 99);
            reset_i   = (sel == 0);
            irq_src_i = 8'($urandom);
            rd_wr_i   = $urandom_range(0, 1) == 1;
            data_i    = 8'($urandom);
            if (sel < 10)
                address_i = 16'($urandom);
            else
                address_i = BASE + 16'($urandom_range(0, 7));
            $display("RND n=%0d rst=%0b addr=%04h wr=%0b data=%02h src=%02h",
                     n, reset_i, address_i, rd_wr_i, data_i, irq_src_i);
        end
        @(negedge clk_i);
        reset_i   = 1'b0;
        address_i = IDLE;
        rd_wr_i   = 1'b0;
        irq_src_i = 8'h00;
        wait_cycles(3);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
